tdm_demux_1_4_b4: RTL and testbench

//   Registered 1-to-4 demultiplexer: the receive-side counterpart of the 4:1 bus mux.

---
 rtl/tdm_demux_1_4_b4.sv | 90 +++++++++
 tb/tb_tdm_demux_1_4_b4.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1_4_b4.sv
// tdm_demux_1_4_b4
//   Registered 1-to-4 demultiplexer. It takes one W-bit beat per cycle and writes it
//   into one of four held output channels. The channel is chosen either by an explicit
//   select or by an internal round-robin slot counter, so a serialised 4-slot TDM stream
//   can be split back into parallel lanes.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset; clears every output register
//   i           input data beat (W bits)
//   s           channel select, used only in addressed mode (mode=0)
//   valid       i carries a real beat this cycle
//   mode        0 = addressed (use s), 1 = auto round-robin (use slot)
//   sync        frame-align pulse; returns the slot counter to 0
//   o0..o3      registered channel outputs; each holds the last value written to it
//   vld         one-hot strobe; vld[k] set means ok was written on the last edge
//   slot        current round-robin slot, which is the channel the next auto beat uses
//   frame_done  single-cycle pulse following the slot-3 beat of an auto frame
//   frame_cnt   count of completed auto frames, wrapping modulo 2^FCNT_W
module tdm_demux_1_4_b4 #(
  parameter int W      = 4,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      i,
  input  logic [1:0]        s,
  input  logic              valid,
  input  logic              mode,
  input  logic              sync,
  output logic [W-1:0]      o0,
  output logic [W-1:0]      o1,
  output logic [W-1:0]      o2,
  output logic [W-1:0]      o3,
  output logic [3:0]        vld,
  output logic [1:0]        slot,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
);

  logic [W-1:0]      o_q [4];
  logic [3:0]        vld_q, vld_d;
  logic [1:0]        slot_q, slot_d;
  logic              fd_q, fd_d;
  logic [FCNT_W-1:0] fc_q;
  logic [1:0]        tgt;

  always_comb begin
    // In auto mode, sync re-aligns the frame, so the beat is forced onto channel 0.
    tgt = mode ? slot_q : s;
    if (mode && sync) tgt = '0;

    // With sync set, a beat in auto mode has already consumed slot 0, so the counter
    // moves on to 1. An addressed beat leaves the counter parked at 0.
    slot_d = slot_q;
    if (sync)               slot_d = (valid && mode) ? 2'd1 : 2'd0;
    else if (valid && mode) slot_d = slot_q + 2'd1;

    fd_d = valid && mode && !sync && (slot_q == 2'd3);

    vld_d = '0;
    if (valid) vld_d[tgt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < 4; k++) o_q[k] <= '0;
      vld_q  <= '0;
      slot_q <= '0;
      fd_q   <= 1'b0;
      fc_q   <= '0;
    end else begin
      if (valid) o_q[tgt] <= i;
      vld_q  <= vld_d;
      slot_q <= slot_d;
      fd_q   <= fd_d;
      if (fd_d) fc_q <= fc_q + FCNT_W'(1);
    end
  end

  assign o0         = o_q[0];
  assign o1         = o_q[1];
  assign o2         = o_q[2];
  assign o3         = o_q[3];
  assign vld        = vld_q;
  assign slot       = slot_q;
  assign frame_done = fd_q;
  assign frame_cnt  = fc_q;

endmodule

// File: tb/tb_tdm_demux_1_4_b4.sv
// Self-checking bench for tdm_demux_1_4_b4 (W=4, FCNT_W=8). A table of hand-derived
// vectors covers reset, addressed and auto routing, sync, mode switching, and mid-frame
// reset. A generated 256-frame run then checks frame_cnt wrap and frame_done pulses.
module tb_tdm_demux_1_4_b4;

  typedef struct packed {
    logic [3:0] o0, o1, o2, o3;
    logic [3:0] vld;
    logic [1:0] slot;
    logic       fd;
    logic [7:0] fc;
  } exp_t;

  typedef struct packed {
    logic       rst, valid, mode, sync;
    logic [1:0] s;
    logic [3:0] i;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, valid, mode, sync;
  logic [1:0] s;
  logic [3:0] i;
  logic [3:0] o0, o1, o2, o3, vld;
  logic [1:0] slot;
  logic       frame_done;
  logic [7:0] frame_cnt;

  int   n_vec  = 0;
  int   n_bad  = 0;
  int   n_fd   = 0;
  exp_t sb_q[$];
  vec_t tbl[22];

  always #5 clk = ~clk;

  tdm_demux_1_4_b4 #(.W(4), .FCNT_W(8)) dut (
    .clk(clk), .rst(rst), .i(i), .s(s), .valid(valid), .mode(mode), .sync(sync),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .vld(vld), .slot(slot),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  function automatic exp_t mke(logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [3:0] d,
                               logic [3:0] v, logic [1:0] sl, logic f, logic [7:0] fc);
    exp_t e;
    e.o0 = a; e.o1 = b; e.o2 = c; e.o3 = d;
    e.vld = v; e.slot = sl; e.fd = f; e.fc = fc;
    return e;
  endfunction

  function automatic vec_t mkv(logic r, logic v, logic m, logic sy, logic [1:0] sel,
                               logic [3:0] din, exp_t e);
    vec_t t;
    t.rst = r; t.valid = v; t.mode = m; t.sync = sy; t.s = sel; t.i = din; t.e = e;
    return t;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, then pop and compare after the edge.
  task automatic apply(input string name, input vec_t t);
    exp_t exp_r, got;
    rst = t.rst; valid = t.valid; mode = t.mode; sync = t.sync; s = t.s; i = t.i;
    sb_q.push_back(t.e);
    @(posedge clk);
    #1;
    exp_r = sb_q.pop_front();
    got   = mke(o0, o1, o2, o3, vld, slot, frame_done, frame_cnt);
    if (frame_done === 1'b1) n_fd++;
    n_vec++;
    if (got !== exp_r) begin
      n_bad++;
      $display("FAIL %s: got o=%h,%h,%h,%h vld=%b slot=%0d fd=%b fc=%0d ; want o=%h,%h,%h,%h vld=%b slot=%0d fd=%b fc=%0d",
               name, got.o0, got.o1, got.o2, got.o3, got.vld, got.slot, got.fd, got.fc,
               exp_r.o0, exp_r.o1, exp_r.o2, exp_r.o3, exp_r.vld, exp_r.slot, exp_r.fd, exp_r.fc);
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; mode = 1'b0; sync = 1'b0; s = '0; i = '0;

    // reset, then release idle
    tbl[0]  = mkv(1,0,0,0,0,4'h0, mke(0,0,0,0, 4'b0000,0,0,0));
    tbl[1]  = mkv(1,0,0,0,0,4'h0, mke(0,0,0,0, 4'b0000,0,0,0));
    tbl[2]  = mkv(0,0,0,0,0,4'h0, mke(0,0,0,0, 4'b0000,0,0,0));
    // addressed beats; invalid garbage must not disturb anything
    tbl[3]  = mkv(0,1,0,0,2,4'hA, mke(0,0,4'hA,0, 4'b0100,0,0,0));
    tbl[4]  = mkv(0,1,0,0,0,4'h5, mke(5,0,4'hA,0, 4'b0001,0,0,0));
    tbl[5]  = mkv(0,0,0,0,3,4'hF, mke(5,0,4'hA,0, 4'b0000,0,0,0));
    // auto frame after a sync
    tbl[6]  = mkv(0,0,1,1,0,4'h0, mke(5,0,4'hA,0, 4'b0000,0,0,0));
    tbl[7]  = mkv(0,1,1,0,0,4'h1, mke(1,0,4'hA,0, 4'b0001,1,0,0));
    tbl[8]  = mkv(0,1,1,0,0,4'h2, mke(1,2,4'hA,0, 4'b0010,2,0,0));
    tbl[9]  = mkv(0,1,1,0,0,4'h3, mke(1,2,3,0,    4'b0100,3,0,0));
    tbl[10] = mkv(0,1,1,0,0,4'h4, mke(1,2,3,4,    4'b1000,0,1,1));
    tbl[11] = mkv(0,0,1,0,0,4'h0, mke(1,2,3,4,    4'b0000,0,0,1));
    // two beats, then sync with a beat -> ch0, slot 1
    tbl[12] = mkv(0,1,1,0,0,4'h8, mke(8,2,3,4,    4'b0001,1,0,1));
    tbl[13] = mkv(0,1,1,0,0,4'h9, mke(8,9,3,4,    4'b0010,2,0,1));
    tbl[14] = mkv(0,1,1,1,0,4'h7, mke(7,9,3,4,    4'b0001,1,0,1));
    // mode switch mid-frame: slot holds through addressed beats
    tbl[15] = mkv(0,1,0,0,3,4'hC, mke(7,9,3,4'hC, 4'b1000,1,0,1));
    tbl[16] = mkv(0,1,1,0,0,4'h6, mke(7,6,3,4'hC, 4'b0010,2,0,1));
    // back-to-back to same channel
    tbl[17] = mkv(0,1,0,0,2,4'hD, mke(7,6,4'hD,4'hC, 4'b0100,2,0,1));
    tbl[18] = mkv(0,1,0,0,2,4'hE, mke(7,6,4'hE,4'hC, 4'b0100,2,0,1));
    // reset mid-frame wins over a valid beat; next auto beat lands in o0
    tbl[19] = mkv(1,1,1,0,0,4'hF, mke(0,0,0,0, 4'b0000,0,0,0));
    tbl[20] = mkv(0,1,1,0,0,4'hB, mke(4'hB,0,0,0, 4'b0001,1,0,0));
    // sync in addressed mode: beat goes to ch s, slot returns to 0
    tbl[21] = mkv(0,1,0,1,3,4'h2, mke(4'hB,0,0,2, 4'b1000,0,0,0));

    for (int k = 0; k < 22; k++) apply($sformatf("vec%0d", k), tbl[k]);

    // 256 full auto frames from reset: data for frame f, beat b is (4f+b) mod 16
    apply("wrap_rst", mkv(1,0,1,0,0,4'h0, mke(0,0,0,0, 4'b0000,0,0,0)));
    n_fd = 0;
    for (int f = 0; f < 256; f++) begin
      for (int b = 0; b < 4; b++) begin
        logic [3:0] ov [4];
        logic [3:0] din;
        logic [3:0] onehot;
        logic [7:0] fc_exp;
        for (int k = 0; k < 4; k++) begin
          if (k <= b)      ov[k] = 4'((4 * f + k) % 16);
          else if (f == 0) ov[k] = 4'h0;
          else             ov[k] = 4'((4 * (f - 1) + k) % 16);
        end
        din    = 4'((4 * f + b) % 16);
        onehot = 4'(1 << b);
        fc_exp = (b == 3) ? 8'((f + 1) % 256) : 8'(f % 256);
        apply($sformatf("frame%0d_beat%0d", f, b),
              mkv(0,1,1,0,0,din, mke(ov[0],ov[1],ov[2],ov[3], onehot, 2'((b + 1) % 4),
                                     (b == 3), fc_exp)));
      end
    end

    n_vec++;
    if (n_fd != 256) begin
      n_bad++;
      $display("FAIL frame_done_count: got %0d want 256", n_fd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
